// File: rtl/mot_adder_pkg.sv
// mot_adder_pkg
//   Shared constants and helpers for the pipelined multi-operand tree adder.
//   - DEF_W / DEF_M  : default operand width and operand count
//   - MODE_*         : encoding of the per-transaction signed/unsigned bit
//   - sum_width()    : full-precision result width, W + clog2(M)
//   - stage_off()    : bit offset of a pipeline stage in the flattened stage bus
package mot_adder_pkg;

    localparam int   DEF_W         = 16;
    localparam int   DEF_M         = 8;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    function automatic int sum_width(input int w, input int m);
        return w + $clog2(m);
    endfunction

    // Stage j carries (m >> j) partial sums of (w + j) bits each; stages are
    // packed back to back starting with stage 1 at offset 0.
    function automatic int stage_off(input int w, input int m, input int k);
        int off;
        off = 0;
        for (int j = 1; j < k; j++) begin
            off += (m >> j) * (w + j);
        end
        return off;
    endfunction

endpackage

// File: rtl/mot_tree_level.sv
// mot_tree_level
//   One combinational level of the adder tree: P ripple-carry adders, each
//   summing an adjacent pair of IW-bit words into an (IW+1)-bit word.
//   Ports:
//     i_ops  [2*P*IW-1:0]   input words, word n = i_ops[n*IW +: IW]
//     i_mode                MODE_SIGNED: sign-extend inputs, else zero-extend
//     o_sums [P*(IW+1)-1:0] pair sums, sum p = words 2p + 2p+1
module mot_tree_level
    import mot_adder_pkg::*;
#(
    parameter int IW = 16,
    parameter int P  = 4
) (
    input  logic [2*P*IW-1:0]   i_ops,
    input  logic                i_mode,
    output logic [P*(IW+1)-1:0] o_sums
);

    localparam int OW = IW + 1;

    logic w_sext;
    assign w_sext = (i_mode == MODE_SIGNED);

    for (genvar p = 0; p < P; p++) begin : g_pair
        logic [IW-1:0] w_a;
        logic [IW-1:0] w_b;
        logic [OW-1:0] w_a_ext;
        logic [OW-1:0] w_b_ext;
        logic [OW-1:0] w_s;
        logic [OW-1:0] w_c;

        assign w_a     = i_ops[(2*p)*IW +: IW];
        assign w_b     = i_ops[(2*p+1)*IW +: IW];
        assign w_a_ext = {w_sext & w_a[IW-1], w_a};
        assign w_b_ext = {w_sext & w_b[IW-1], w_b};

        // The extra bit makes the pair sum exact, so the final carry is
        // never needed and is not generated.
        assign w_c[0] = 1'b0;
        for (genvar b = 0; b < OW; b++) begin : g_bit
            assign w_s[b] = w_a_ext[b] ^ w_b_ext[b] ^ w_c[b];
            if (b < OW - 1) begin : g_carry
                assign w_c[b+1] = (w_a_ext[b] & w_b_ext[b])
                                | (w_c[b] & (w_a_ext[b] ^ w_b_ext[b]));
            end
        end

        assign o_sums[p*OW +: OW] = w_s;
    end

endmodule

// File: rtl/mot_tree_adder_pipe.sv
// mot_tree_adder_pipe
//   Pipelined binary tree adder: sums M operands of W bits per transaction,
//   one register stage after every tree level, valid/ready on both sides.
//   Ports:
//     clk, rst            clock; synchronous active-high reset
//     in_valid/in_ready   input handshake
//     in_ops [M*W-1:0]    operand j = in_ops[j*W +: W]
//     in_signed           1: two's complement operands, 0: unsigned
//     out_valid/out_ready output handshake
//     out_sum [W+L-1:0]   exact sum
//     out_signed          mode bit of the transaction on out_sum
module mot_tree_adder_pipe
    import mot_adder_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int M = DEF_M,
    parameter int L = $clog2(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M*W-1:0]   in_ops,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W+L-1:0]   out_sum,
    output logic             out_signed
);

    localparam int SW  = sum_width(W, M);
    localparam int TOT = stage_off(W, M, L + 1);

    logic [L:1]     w_vld;
    logic [L:1]     w_sgn;
    logic [L:1]     w_rdy;
    logic [TOT-1:0] w_stage_q;

    for (genvar k = 1; k <= L; k++) begin : g_stage
        localparam int IW  = W + k - 1;
        localparam int P   = M >> k;
        localparam int OW  = W + k;
        localparam int OFF = stage_off(W, M, k);

        logic [2*P*IW-1:0] w_in;
        logic              w_mode;
        logic              w_vld_in;
        logic [P*OW-1:0]   w_sum;
        logic [P*OW-1:0]   r_data;
        logic              r_vld;
        logic              r_sgn;

        if (k == 1) begin : g_first
            assign w_in     = in_ops;
            assign w_mode   = in_signed;
            assign w_vld_in = in_valid;
        end else begin : g_next
            assign w_in     = w_stage_q[stage_off(W, M, k - 1) +: 2*P*IW];
            assign w_mode   = w_sgn[k-1];
            assign w_vld_in = w_vld[k-1];
        end

        mot_tree_level #(
            .IW (IW),
            .P  (P)
        ) u_level (
            .i_ops  (w_in),
            .i_mode (w_mode),
            .o_sums (w_sum)
        );

        // Unrolled ready chain: stage k may load if the output side takes a
        // word, or if any stage from k to the output holds a bubble.
        assign w_rdy[k] = out_ready || !(&w_vld[L:k]);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data <= '0;
                r_vld  <= 1'b0;
                r_sgn  <= MODE_UNSIGNED;
            end else if (w_rdy[k]) begin
                r_data <= w_sum;
                r_vld  <= w_vld_in;
                r_sgn  <= w_mode;
            end
        end

        assign w_stage_q[OFF +: P*OW] = r_data;
        assign w_vld[k]               = r_vld;
        assign w_sgn[k]               = r_sgn;
    end

    assign in_ready   = w_rdy[1];
    assign out_valid  = w_vld[L];
    assign out_signed = w_sgn[L];
    assign out_sum    = w_stage_q[stage_off(W, M, L) +: SW];

endmodule
